// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-configuration field widths and the
// transmit-arbiter FSM state encoding.
package uart_pkg;

    localparam int STOP_CONF_W   = 1;
    localparam int DATA_CONF_W   = 2;
    localparam int PARITY_CONF_W = 2;
    localparam int TOTAL_CONF_W  = STOP_CONF_W + DATA_CONF_W + PARITY_CONF_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } tx_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible request at or above the
// pointer, wrapping. Eligible means requested and not masked off.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic [N-1:0]     mask_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [N-1:0] elig;

    function automatic logic [IDX_W-1:0] slot(input logic [IDX_W-1:0] ptr, input int ofs);
        return IDX_W'((int'(ptr) + ofs) % N);
    endfunction

    assign elig = req_i & mask_i;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any_o && elig[slot(ptr_i, i)]) begin
                grant_o[slot(ptr_i, i)] = 1'b1;
                idx_o                   = slot(ptr_i, i);
                any_o                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one tx_module between NUM_REQ clients.
// Optional burst locking is compiled in with `define UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_UART_DATA_W = 8,
    parameter int TOTAL_CONF_W    = 5,
    parameter int REQ_IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 en_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    input  logic [NUM_REQ*MAX_UART_DATA_W-1:0]   req_data_i,
    input  logic [NUM_REQ*TOTAL_CONF_W-1:0]      req_conf_i,
    input  logic [NUM_REQ-1:0]                   req_lock_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    output logic [NUM_REQ-1:0]                   req_done_o,
    output logic                                 tx_en_o,
    output logic                                 tx_start_o,
    output logic [TOTAL_CONF_W-1:0]              tx_conf_o,
    output logic [MAX_UART_DATA_W-1:0]           tx_data_o,
    input  logic                                 tx_done_i,
    output logic                                 busy_o,
    output logic [REQ_IDX_W-1:0]                 grant_idx_o
);

    import uart_pkg::*;

    tx_arb_state_t              state_q, state_nxt;
    logic [REQ_IDX_W-1:0]       rr_ptr_q, rr_ptr_nxt, arb_ptr, arb_idx, grant_idx_q;
    logic [NUM_REQ-1:0]         arb_mask, arb_grant, done_p1;
    logic                       arb_any, handshake, done_in_wait;
    logic [MAX_UART_DATA_W-1:0] data_q;
    logic [TOTAL_CONF_W-1:0]    conf_q;

    function automatic logic [REQ_IDX_W-1:0] wrap_inc(input logic [REQ_IDX_W-1:0] idx);
        if (idx == REQ_IDX_W'(NUM_REQ - 1)) return '0;
        return idx + 1'b1;
    endfunction

`ifdef UART_TX_ARB_LOCK_EN
    logic lock_act_q, lock_hold;

    // A lock only holds while the owner keeps both lock and valid high.
    assign lock_hold = lock_act_q && req_lock_i[grant_idx_q] && req_valid_i[grant_idx_q];
    assign arb_mask  = lock_hold ? (NUM_REQ'(1) << grant_idx_q) : '1;
    assign arb_ptr   = (lock_act_q && !lock_hold) ? wrap_inc(grant_idx_q) : rr_ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            lock_act_q <= 1'b0;
        else if (done_in_wait)
            lock_act_q <= req_lock_i[grant_idx_q];
        else if (state_q == IDLE && !lock_hold)
            lock_act_q <= 1'b0;
    end
`else
    logic unused_lock;

    assign unused_lock = ^req_lock_i;
    assign arb_mask    = '1;
    assign arb_ptr     = rr_ptr_q;
`endif

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (REQ_IDX_W)
    ) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (arb_ptr),
        .mask_i  (arb_mask),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign handshake    = (state_q == IDLE) && en_i && arb_any;
    assign done_in_wait = (state_q == WAIT) && tx_done_i;

    always_comb begin
        rr_ptr_nxt = rr_ptr_q;
        if (handshake)
            rr_ptr_nxt = wrap_inc(arb_idx);
`ifdef UART_TX_ARB_LOCK_EN
        else if (done_in_wait && req_lock_i[grant_idx_q])
            rr_ptr_nxt = grant_idx_q;
        else if (state_q == IDLE && lock_act_q && !lock_hold)
            rr_ptr_nxt = wrap_inc(grant_idx_q);
`endif
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:    if (handshake) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (tx_done_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_nxt;
            rr_ptr_q <= rr_ptr_nxt;
        end
    end

    // Capture stage: held stable from LAUNCH through WAIT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q      <= '0;
            conf_q      <= '0;
            grant_idx_q <= '0;
        end else if (handshake) begin
            data_q      <= req_data_i[arb_idx*MAX_UART_DATA_W +: MAX_UART_DATA_W];
            conf_q      <= req_conf_i[arb_idx*TOTAL_CONF_W +: TOTAL_CONF_W];
            grant_idx_q <= arb_idx;
        end
    end

    // Completion stage: one-cycle notice to the client that was served.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            done_p1 <= '0;
        else
            done_p1 <= done_in_wait ? (NUM_REQ'(1) << grant_idx_q) : '0;
    end

    assign req_ready_o = ((state_q == IDLE) && en_i) ? arb_grant : '0;
    assign req_done_o  = done_p1;
    assign busy_o      = (state_q != IDLE);
    assign tx_en_o     = en_i | busy_o;
    assign tx_start_o  = (state_q == LAUNCH);
    assign tx_data_o   = data_q;
    assign tx_conf_o   = conf_q;
    assign grant_idx_o = grant_idx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: the bench plays tx_module and
// predicts grant order with an abstract round-robin / lock model.
module tb_uart_tx_arbiter;

    logic        clk, rst, en, tx_done;
    logic [3:0]  req_valid, req_lock, req_ready, req_done;
    logic [31:0] req_data;
    logic [19:0] req_conf;
    logic        tx_en, tx_start, busy;
    logic [4:0]  tx_conf;
    logic [7:0]  tx_data;
    logic [1:0]  grant_idx;

    logic [7:0]  cdata [4];
    logic [4:0]  cconf [4];

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;
    int m_owner  = -1;

    typedef struct {
        bit         hs;
        int         idx;
        logic [7:0] data;
        logic [4:0] conf;
        logic [7:0] data_late;
        logic [4:0] conf_late;
        logic [1:0] gidx;
        bit         start_ok;
        bit         start_once;
        bit         busy_wait;
        bit         txen_wait;
        logic [3:0] done_vec;
        bit         busy_after;
    } obs_t;

    uart_tx_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_conf_i  (req_conf),
        .req_lock_i  (req_lock),
        .req_ready_o (req_ready),
        .req_done_o  (req_done),
        .tx_en_o     (tx_en),
        .tx_start_o  (tx_start),
        .tx_conf_o   (tx_conf),
        .tx_data_o   (tx_data),
        .tx_done_i   (tx_done),
        .busy_o      (busy),
        .grant_idx_o (grant_idx)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        req_conf = '0;
        for (int k = 0; k < 4; k++) begin
            req_data[k*8 +: 8] = cdata[k];
            req_conf[k*5 +: 5] = cconf[k];
        end
    end

    // Reference: serve the lock owner while it still wants service, otherwise
    // the first valid client at or after the rotating pointer.
    function automatic int model_pick(input logic [3:0] v, input logic [3:0] lk);
        int w = -1;
        if (m_owner >= 0 && v[m_owner] && lk[m_owner]) begin
            w = m_owner;
        end else begin
            if (m_owner >= 0) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end
            for (int i = 0; i < 4; i++)
                if (w < 0 && v[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
        end
        if (w >= 0) m_ptr = (w + 1) % 4;
        return w;
    endfunction

    function automatic void model_done(input int w, input logic [3:0] lk);
`ifdef UART_TX_ARB_LOCK_EN
        m_owner = (w >= 0 && lk[w]) ? w : -1;
`else
        m_owner = (w >= 0 && lk[w] && 1'b0) ? w : -1;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst = 1'b1; en = 1'b0; req_valid = '0; req_lock = '0; tx_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        m_ptr = 0;
        m_owner = -1;
    endtask

    // Acts as tx_module for one byte: waits for a handshake, observes the
    // launch, holds the frame for 'frame' cycles, then pulses done.
    task automatic do_byte(input int frame, input logic [3:0] lock_done, input bit drop_en,
                           input bit scramble, output obs_t o);
        int n = 0;
        o = '{default: '0};
        o.idx = -1;
        #1;
        while ((req_ready & req_valid) == 4'b0000 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) return;
        o.hs = 1'b1;
        for (int k = 0; k < 4; k++) if (req_ready[k] && req_valid[k]) o.idx = k;
        @(negedge clk);
        if (scramble)
            for (int k = 0; k < 4; k++) begin
                cdata[k] = 8'($urandom);
                cconf[k] = 5'($urandom);
            end
        #1;
        o.start_ok = tx_start; o.data = tx_data; o.conf = tx_conf; o.gidx = grant_idx;
        tick();
        o.start_once = !tx_start;
        o.busy_wait  = busy;
        if (drop_en) en = 1'b0;
        req_lock = lock_done;
        repeat (frame) @(negedge clk);
        #1;
        o.txen_wait = tx_en;
        o.busy_wait = o.busy_wait & busy;
        o.data_late = tx_data;
        o.conf_late = tx_conf;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        #1;
        o.done_vec   = req_done;
        o.busy_after = busy;
    endtask

    task automatic test_reset();
        rst_pulse();
        rst = 1'b1;
        tick();
        n_checks++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL rst_ready got=%b want=0000", req_ready); end
        n_checks++; if (req_done !== 4'b0) begin n_fail++; $display("FAIL rst_done got=%b want=0000", req_done); end
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_start got=%b want=0", tx_start); end
        n_checks++; if (tx_en !== 1'b0) begin n_fail++; $display("FAIL rst_txen got=%b want=0", tx_en); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_data got=%h want=00", tx_data); end
        n_checks++; if (tx_conf !== 5'h00) begin n_fail++; $display("FAIL rst_conf got=%h want=00", tx_conf); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", busy); end
        n_checks++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL rst_gidx got=%0d want=0", grant_idx); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stray_done();
        en = 1'b1; req_valid = '0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0 || req_done !== 4'b0 || tx_start !== 1'b0) begin
            n_fail++; $display("FAIL stray_done busy=%b done=%b start=%b want 0/0000/0", busy, req_done, tx_start);
        end
    endtask

    task automatic test_single();
        obs_t o;
        int   w;
        cdata[2] = 8'hAA; cconf[2] = 5'b11000;
        en = 1'b1; req_valid = 4'b0100;
        w = model_pick(req_valid, '0);
        do_byte(10, '0, 1'b0, 1'b0, o);
        req_valid = '0;
        model_done(w, '0);
        n_checks++; if (!o.hs || o.idx !== w) begin n_fail++; $display("FAIL single_idx got=%0d want=%0d", o.idx, w); end
        n_checks++; if (o.start_ok !== 1'b1) begin n_fail++; $display("FAIL single_start got=%b want=1", o.start_ok); end
        n_checks++; if (o.data !== 8'hAA) begin n_fail++; $display("FAIL single_data got=%h want=aa", o.data); end
        n_checks++; if (o.conf !== 5'b11000) begin n_fail++; $display("FAIL single_conf got=%b want=11000", o.conf); end
        n_checks++; if (o.gidx !== 2'd2) begin n_fail++; $display("FAIL single_gidx got=%0d want=2", o.gidx); end
        n_checks++; if (o.start_once !== 1'b1) begin n_fail++; $display("FAIL single_start_width start still high"); end
        n_checks++; if (o.busy_wait !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b want=1", o.busy_wait); end
        n_checks++; if (o.done_vec !== 4'b0100) begin n_fail++; $display("FAIL single_done got=%b want=0100", o.done_vec); end
        n_checks++; if (o.busy_after !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got=%b want=0", o.busy_after); end
        tick();
        n_checks++; if (req_done !== 4'b0) begin n_fail++; $display("FAIL single_done_width got=%b want=0000", req_done); end
    endtask

    task automatic test_round_robin();
        obs_t o;
        int   w;
        logic [3:0] exp_done;
        rst_pulse();
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin cdata[k] = 8'h10 + 8'(k); cconf[k] = 5'(k); end
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            w = model_pick(req_valid, '0);
            do_byte(int'($urandom_range(1, 6)), '0, 1'b0, 1'b0, o);
            model_done(w, '0);
            exp_done = 4'b0001 << w;
            n_checks++; if (o.idx !== w || o.gidx !== 2'(w)) begin n_fail++; $display("FAIL rr_order[%0d] got=%0d/%0d want=%0d", i, o.idx, o.gidx, w); end
            n_checks++; if (o.data !== 8'h10 + 8'(w)) begin n_fail++; $display("FAIL rr_data[%0d] got=%h want=%h", i, o.data, 8'h10 + 8'(w)); end
            n_checks++; if (o.done_vec !== exp_done) begin n_fail++; $display("FAIL rr_done[%0d] got=%b want=%b", i, o.done_vec, exp_done); end
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        obs_t o;
        int   w;
        logic [7:0] ed;
        logic [4:0] ec;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 4; k++) begin cdata[k] = 8'($urandom); cconf[k] = 5'($urandom); end
            req_valid = 4'($urandom_range(1, 15));
            w  = model_pick(req_valid, '0);
            ed = cdata[w];
            ec = cconf[w];
            do_byte(int'($urandom_range(1, 8)), '0, 1'b0, 1'b1, o);
            model_done(w, '0);
            n_checks++; if (o.idx !== w) begin n_fail++; $display("FAIL rand_idx[%0d] got=%0d want=%0d", i, o.idx, w); end
            n_checks++; if (o.data !== ed || o.conf !== ec) begin n_fail++; $display("FAIL rand_payload[%0d] got=%h/%h want=%h/%h", i, o.data, o.conf, ed, ec); end
            n_checks++; if (o.data_late !== ed || o.conf_late !== ec) begin n_fail++; $display("FAIL rand_hold[%0d] got=%h/%h want=%h/%h", i, o.data_late, o.conf_late, ed, ec); end
        end
        req_valid = '0;
    endtask

    task automatic test_en_drop();
        obs_t o;
        int   w;
        logic [3:0] seen;
        en = 1'b1; req_valid = 4'b0010;
        w = model_pick(req_valid, '0);
        do_byte(6, '0, 1'b1, 1'b0, o);
        model_done(w, '0);
        n_checks++; if (o.idx !== w) begin n_fail++; $display("FAIL endrop_idx got=%0d want=%0d", o.idx, w); end
        n_checks++; if (o.txen_wait !== 1'b1) begin n_fail++; $display("FAIL endrop_txen_wait got=%b want=1", o.txen_wait); end
        n_checks++; if (tx_en !== 1'b0) begin n_fail++; $display("FAIL endrop_txen_after got=%b want=0", tx_en); end
        seen = req_ready;
        repeat (3) begin tick(); seen = seen | req_ready; end
        n_checks++; if (seen !== 4'b0) begin n_fail++; $display("FAIL endrop_ready got=%b want=0000", seen); end
        en = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL endrop_reenable got=%b want=0010", req_ready); end
        w = model_pick(req_valid, '0);
        do_byte(2, '0, 1'b0, 1'b0, o);
        model_done(w, '0);
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int   w;
        en = 1'b1; req_valid = 4'b0010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL midrst_ready got=%b want=0010", req_ready); end
        tick();
        req_valid = '0;
        n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL midrst_start got=%b want=1", tx_start); end
        tick();
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        tick();
        n_checks++; if ({tx_start, busy, tx_en, tx_data, tx_conf, grant_idx, req_done, req_ready} !== '0) begin
            n_fail++; $display("FAIL midrst_zero start=%b busy=%b txen=%b data=%h conf=%h gidx=%0d done=%b ready=%b want all 0",
                               tx_start, busy, tx_en, tx_data, tx_conf, grant_idx, req_done, req_ready);
        end
        rst = 1'b0; en = 1'b1;
        m_ptr = 0; m_owner = -1;
        req_valid = 4'b1111;
        w = model_pick(req_valid, '0);
        do_byte(3, '0, 1'b0, 1'b0, o);
        model_done(w, '0);
        n_checks++; if (o.idx !== w) begin n_fail++; $display("FAIL midrst_ptr got=%0d want=%0d", o.idx, w); end
        req_valid = 4'b1000;
        w = model_pick(req_valid, '0);
        do_byte(3, '0, 1'b0, 1'b0, o);
        model_done(w, '0);
        n_checks++; if (o.idx !== w) begin n_fail++; $display("FAIL midrst_client3 got=%0d want=%0d", o.idx, w); end
        req_valid = '0;
    endtask

    task automatic test_lock();
        obs_t o;
        int   w;
        int   cnt1 = 0;
        logic [3:0] lk_g, lk_d;
        rst_pulse();
        en = 1'b1;
        req_valid = 4'b0001;
        w = model_pick(req_valid, '0);
        do_byte(2, '0, 1'b0, 1'b0, o);
        model_done(w, '0);
        n_checks++; if (o.idx !== w) begin n_fail++; $display("FAIL lock_prime got=%0d want=%0d", o.idx, w); end
        req_valid = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            lk_g = (cnt1 < 3) ? 4'b0010 : 4'b0000;
            lk_d = (cnt1 < 2) ? 4'b0010 : 4'b0000;
            req_lock = lk_g;
            w = model_pick(req_valid, lk_g);
            do_byte(3, lk_d, 1'b0, 1'b0, o);
            model_done(w, lk_d);
            if (w == 1) cnt1++;
            n_checks++; if (o.idx !== w) begin n_fail++; $display("FAIL lock_order[%0d] got=%0d want=%0d", i, o.idx, w); end
        end
        req_lock = '0; req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; rst = 1'b1; en = 1'b0; tx_done = 1'b0;
        req_valid = '0; req_lock = '0;
        for (int k = 0; k < 4; k++) begin cdata[k] = '0; cconf[k] = '0; end
        test_reset();
        test_stray_done();
        test_single();
        test_round_robin();
        test_random();
        test_en_drop();
        test_reset_mid();
        test_lock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
